// File: rtl/rv_core_pkg.sv
// Shared core definitions: fetch state encoding, reset/NOP constants and the
// RV32I opcode values the fetch stage and main_decoder agree on.
package rv_core_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // Fetch FSM encoding, kept as plain constants so legacy blocks can reuse it.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FS_REQ   = 2'd0;
    localparam fetch_state_t FS_WAIT  = 2'd1;
    localparam fetch_state_t FS_HOLD  = 2'd2;
    localparam fetch_state_t FS_DRAIN = 2'd3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word request to imem, a single held
// instruction toward decode, and branch redirects that squash wrong-path fetches.
module fetch_unit
    import rv_core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_word;

    assign pc_plus4      = pc + XLEN'(4);
    assign redirect_word = redirect_pc & ~XLEN'(3);

    // The request is gated by rst so nothing reaches memory during a reset cycle.
    assign imem_req  = (state == FS_REQ) && !rst;
    assign imem_addr = pc;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FS_REQ;
            pc          <= RESET_PC;
            instr       <= XLEN'(NOP_INSTR);
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            // A redirect wins over everything; any granted or held fetch is wrong-path.
            pc          <= redirect_word;
            instr_valid <= 1'b0;
            case (state)
                FS_REQ:  state <= imem_gnt ? FS_DRAIN : FS_REQ;
                FS_WAIT: state <= imem_rvalid ? FS_REQ : FS_DRAIN;
                FS_HOLD: state <= FS_REQ;
                default: state <= imem_rvalid ? FS_REQ : FS_DRAIN;
            endcase
        end else begin
            case (state)
                FS_REQ: begin
                    if (imem_gnt) state <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc_plus4;
                        state       <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= FS_REQ;
                    end
                end
                default: begin
                    // DRAIN: the squashed response is dropped on arrival.
                    if (imem_rvalid) state <= FS_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory timing,
// backpressure and redirects, checked by a program-order scoreboard.
module tb_fetch_unit;
    import rv_core_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: the address of the next instruction decode must receive.
    logic [31:0] sb[$];
    logic [31:0] cons_pc[$];
    int          cons_cyc[$];
    int          cons_total = 0;
    int          cyc = 0;
    int          rel_cyc = 0;

    // Memory model knobs
    int gnt_pct = 100;
    int lat_min = 0;
    int lat_max = 0;
    bit poison  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // ---------------- memory model (drives at negedge + 1) ----------------
    initial begin
        bit          outstanding = 1'b0;
        bit          grant_q = 1'b0;
        int          cnt = 0;
        logic [31:0] oaddr = '0;
        logic [31:0] gaddr_q = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                outstanding = 1'b0;
                grant_q     = 1'b0;
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
            end else begin
                if (imem_rvalid) outstanding = 1'b0;
                if (grant_q) begin
                    outstanding = 1'b1;
                    oaddr       = gaddr_q;
                    cnt         = int'($urandom_range(lat_max, lat_min));
                end
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
                if (outstanding) begin
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = poison ? 32'hDEAD_BEEF : mem_word(oaddr);
                        poison      = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (imem_req) begin
                    imem_gnt = ($urandom_range(99, 0) < gnt_pct);
                end
                grant_q = imem_gnt && imem_req;
                gaddr_q = imem_addr;
            end
        end
    end

    // ---------------- monitor / scoreboard (samples at negedge + 2) ----------------
    initial begin
        bit          prev_rst = 1'b0;
        bit          prev_valid = 1'b0;
        bit          prev_cons = 1'b0;
        bit          prev_redir = 1'b0;
        logic [31:0] prev_instr = '0;
        logic [31:0] prev_ipc = '0;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                check("req_during_reset", {31'b0, imem_req}, 32'd0);
            end else begin
                if (prev_rst) begin
                    rel_cyc = cyc;
                    check("reset_valid", {31'b0, instr_valid}, 32'd0);
                    check("reset_instr", instr, NOP_INSTR);
                    check("reset_instr_pc", instr_pc, 32'h0);
                    check("reset_addr", imem_addr, 32'h0);
                    check("reset_req", {31'b0, imem_req}, 32'd1);
                end
                check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                check("req_while_valid", {31'b0, imem_req && instr_valid}, 32'd0);
                if (prev_valid && !prev_cons && !prev_redir && !prev_rst && instr_valid) begin
                    check("hold_instr_stable", instr, prev_instr);
                    check("hold_pc_stable", instr_pc, prev_ipc);
                end
                if (imem_req && imem_gnt && !redirect_valid) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL fetch_addr: got %h expected none (empty scoreboard)", imem_addr);
                    end else begin
                        check("fetch_addr", imem_addr, sb[0]);
                    end
                end
                if (instr_valid && instr_ready && !redirect_valid) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL deliver: got pc %h expected none (empty scoreboard)", instr_pc);
                    end else begin
                        exp = sb.pop_front();
                        check("deliver_pc", instr_pc, exp);
                        check("deliver_data", instr, mem_word(exp));
                        sb.push_back(exp + 32'd4);
                    end
                    cons_pc.push_back(instr_pc);
                    cons_cyc.push_back(cyc);
                    cons_total++;
                end
            end
            prev_rst   = rst;
            prev_valid = instr_valid;
            prev_cons  = instr_valid && instr_ready;
            prev_redir = redirect_valid;
            prev_instr = instr;
            prev_ipc   = instr_pc;
        end
    end

    // ---------------- stimulus helpers (drive at negedge) ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        sb.delete();
        sb.push_back(32'h0);
        cons_pc.delete();
        cons_cyc.delete();
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called right after a negedge; the pulse is removed at the next negedge by the caller.
    task automatic issue_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        sb.delete();
        sb.push_back(target & ~32'd3);
    endtask

    // what: 0 = instr_valid, 1 = granted request, 2 = request
    task automatic wait_for(input int what, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            #3;
            case (what)
                0:       hit = instr_valid;
                1:       hit = imem_req && imem_gnt;
                default: hit = imem_req;
            endcase
        end
        if (!hit) begin
            checks++; failures++;
            $display("FAIL %s: event never seen within 60 cycles", name);
        end
    endtask

    task automatic wait_cons(input int n, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            #3;
            ok = (cons_pc.size() > n);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s: no delivery within 60 cycles", name);
        end
    endtask

    initial begin
        bit          ok;
        int          n;
        logic [31:0] p;
        logic [31:0] w;

        sb.push_back(32'h0);

        // 1) zero-wait memory, always ready
        instr_ready = 1'b1;
        do_reset(2);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            #3;
            ok = (cons_pc.size() >= 3);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL zero_wait: got %0d deliveries expected 3", cons_pc.size());
        end else begin
            check("zw_pc0", cons_pc[0], 32'h0);
            check("zw_pc1", cons_pc[1], 32'h4);
            check("zw_pc2", cons_pc[2], 32'h8);
            check("zw_latency", 32'(cons_cyc[0] - rel_cyc), 32'd2);
            check("zw_gap1", 32'(cons_cyc[1] - cons_cyc[0]), 32'd3);
            check("zw_gap2", 32'(cons_cyc[2] - cons_cyc[1]), 32'd3);
        end

        // 2) backpressure in HOLD
        @(negedge clk);
        instr_ready = 1'b0;
        wait_for(0, "bp_valid");
        p = instr_pc;
        w = instr;
        repeat (5) begin
            @(negedge clk);
            #3;
            check("bp_req_low", {31'b0, imem_req}, 32'd0);
            check("bp_valid_high", {31'b0, instr_valid}, 32'd1);
            check("bp_instr", instr, w);
            check("bp_pc", instr_pc, p);
        end
        @(negedge clk);
        instr_ready = 1'b1;
        @(negedge clk);
        #3;
        check("bp_next_req", {31'b0, imem_req}, 32'd1);
        check("bp_next_addr", imem_addr, p + 32'd4);

        // 3) redirect while WAIT, squashed data is poisoned
        lat_min = 2;
        lat_max = 2;
        wait_for(1, "rw_grant");
        @(negedge clk);
        poison = 1'b1;
        issue_redirect(32'h0000_0100);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("rw_no_valid", {31'b0, instr_valid}, 32'd0);
        n = cons_pc.size();
        wait_for(2, "rw_req");
        check("rw_addr", imem_addr, 32'h0000_0100);
        lat_min = 0;
        lat_max = 0;
        wait_cons(n, "rw_deliver", ok);
        if (ok) check("rw_first_pc", cons_pc[n], 32'h0000_0100);

        // 4) redirect in HOLD with instr_ready high in the same cycle
        @(negedge clk);
        instr_ready = 1'b0;
        wait_for(0, "rh_valid");
        n = cons_pc.size();
        @(negedge clk);
        instr_ready = 1'b1;
        issue_redirect(32'h0000_0203);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("rh_valid_drop", {31'b0, instr_valid}, 32'd0);
        check("rh_req", {31'b0, imem_req}, 32'd1);
        check("rh_addr", imem_addr, 32'h0000_0200);
        wait_cons(n, "rh_deliver", ok);
        if (ok) check("rh_first_pc", cons_pc[n], 32'h0000_0200);

        // 5) wrap-around
        @(negedge clk);
        issue_redirect(32'hFFFF_FFFC);
        @(negedge clk);
        redirect_valid = 1'b0;
        n = cons_pc.size();
        wait_for(1, "wrap_grant0");
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        wait_cons(n, "wrap_deliver", ok);
        if (ok) check("wrap_pc", cons_pc[n], 32'hFFFF_FFFC);
        wait_for(1, "wrap_grant1");
        check("wrap_addr1", imem_addr, 32'h0000_0000);

        // 6) reset in the middle of WAIT
        lat_min = 2;
        lat_max = 2;
        wait_for(1, "rst_grant");
        do_reset(1);
        lat_min = 0;
        lat_max = 0;
        #3;
        check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("mid_rst_instr", instr, NOP_INSTR);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_req", {31'b0, imem_req}, 32'd1);

        // 7) randomized traffic
        gnt_pct = 60;
        lat_min = 0;
        lat_max = 3;
        n = cons_total;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            rst = 1'b0;
            instr_ready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(999, 0) < 5) begin
                rst = 1'b1;
                sb.delete();
                sb.push_back(32'h0);
            end else if ($urandom_range(99, 0) < 4) begin
                if ($urandom_range(4, 0) == 0) issue_redirect(32'hFFFF_FFF0 | $urandom_range(15, 0));
                else issue_redirect($urandom);
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        rst = 1'b0;
        instr_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("random_progress", {31'b0, (cons_total - n) > 100}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
